// File: rtl/msdf_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : msdf_mul_seq
//  Description : Request/response sequencer around a serial MSD-first online
//                multiplier. Latches an operand pair, loads Y, pulses start,
//                streams the X digits MSD first, collects N result digits
//                (with a drain timeout) and presents them as a parallel word.
//  Revision    : 1.0 - initial release
// ============================================================================
//  Radix-2 signed digit encoding: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1.
// ============================================================================
module msdf_mul_seq #(
  parameter int N     = 8,
  parameter int DELTA = 4,
  parameter int TMO   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [2*N-1:0] x_vec,
  input  logic [N:0]     y_in,
  output logic [N:0]     mul_y,
  output logic           mul_load_y,
  output logic           mul_start,
  output logic [1:0]     mul_xdigit,
  input  logic [1:0]     mul_z,
  input  logic           mul_z_ready,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] z_vec,
  output logic           res_err,
  output logic           busy
);

  localparam logic [1:0] R2_ZERO = 2'b00;

  // Counters must reach the last FEED index and the last DRAIN index without wrapping.
  localparam int FEED_LAST = N + DELTA;
  localparam int CNT_MAX   = (FEED_LAST + 1 > TMO) ? (FEED_LAST + 1) : TMO;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_ONE       = CW'(1);
  localparam logic [CW-1:0] C_FEED_LAST = CW'(FEED_LAST);
  localparam logic [CW-1:0] C_TMO_LAST  = CW'(TMO - 1);
  localparam logic [CW-1:0] C_N         = CW'(N);
  localparam logic [CW-1:0] C_N_M1      = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_FEED  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t         state_q;
  logic [2*N-1:0] x_q;
  logic [N:0]     y_q;
  logic [2*N-1:0] z_q;
  logic [CW-1:0]  cnt_q;     // feed_cnt in FEED, drain cycle count in DRAIN
  logic [CW-1:0]  z_cnt_q;   // number of result digits collected
  logic           err_q;
  logic           load_y_q;
  logic           start_q;
  logic [1:0]     xdig_q;
  logic           valid_q;
  logic           busy_q;

  logic [CW-1:0]  cnt_next_d;
  logic [1:0]     next_dig_d;
  logic [2*N-1:0] z_d;
  logic           take_d;
  logic           last_d;

  assign cnt_next_d = cnt_q + C_ONE;

  // A result digit is accepted only while the multiplier is running and the buffer has room.
  assign take_d = mul_z_ready && (z_cnt_q < C_N) &&
                  ((state_q == S_FEED) || (state_q == S_DRAIN));
  assign last_d = take_d && (z_cnt_q == C_N_M1);

  // Select the X digit for the next FEED cycle; indices at or beyond N feed zeros.
  always_comb begin
    next_dig_d = R2_ZERO;
    for (int k = 0; k < N; k++) begin
      if (cnt_next_d == CW'(k)) next_dig_d = x_q[2*k +: 2];
    end
  end

  // Write an accepted result digit into its slot of the result buffer.
  always_comb begin
    z_d = z_q;
    for (int k = 0; k < N; k++) begin
      if (take_d && (z_cnt_q == CW'(k))) z_d[2*k +: 2] = mul_z;
    end
  end

  // Sequencer FSM with registered multiplier and result-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      cnt_q    <= '0;
      z_cnt_q  <= '0;
      err_q    <= 1'b0;
      load_y_q <= 1'b0;
      start_q  <= 1'b0;
      xdig_q   <= R2_ZERO;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            x_q      <= x_vec;
            y_q      <= y_in;
            load_y_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          load_y_q <= 1'b0;
          start_q  <= 1'b1;
          z_q      <= '0;
          z_cnt_q  <= '0;
          cnt_q    <= '0;
          err_q    <= 1'b0;
          state_q  <= S_START;
        end
        S_START: begin
          start_q <= 1'b0;
          xdig_q  <= x_q[1:0];
          cnt_q   <= '0;
          state_q <= S_FEED;
        end
        S_FEED: begin
          z_q <= z_d;
          if (take_d) z_cnt_q <= z_cnt_q + C_ONE;
          if (last_d) begin
            xdig_q  <= R2_ZERO;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else if (cnt_q == C_FEED_LAST) begin
            xdig_q  <= R2_ZERO;
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else begin
            cnt_q  <= cnt_next_d;
            xdig_q <= next_dig_d;
          end
        end
        S_DRAIN: begin
          z_q <= z_d;
          if (take_d) z_cnt_q <= z_cnt_q + C_ONE;
          // The Nth digit wins over a timeout landing on the same cycle.
          if (last_d) begin
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else if (cnt_q == C_TMO_LAST) begin
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_next_d;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is masked by reset so it reads low for the whole reset assertion.
  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign mul_y      = y_q;
  assign mul_load_y = load_y_q;
  assign mul_start  = start_q;
  assign mul_xdigit = xdig_q;
  assign res_valid  = valid_q;
  assign z_vec      = z_q;
  assign res_err    = err_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_msdf_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msdf_mul_seq
//  Description : Self-checking bench for msdf_mul_seq with a mock serial
//                multiplier whose result-digit timing is chosen per vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msdf_mul_seq;

  localparam int N       = 8;
  localparam int DELTA   = 4;
  localparam int TMO     = 16;
  localparam int DONE_TO = N + DELTA + 1 + TMO;   // FEED-relative cycle of a timeout DONE

  localparam logic [1:0] DZ = 2'b00;
  localparam logic [1:0] DP = 2'b01;
  localparam logic [1:0] DM = 2'b11;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [2*N-1:0] x_vec = '0;
  logic [N:0]     y_in = '0;
  logic [N:0]     mul_y;
  logic           mul_load_y;
  logic           mul_start;
  logic [1:0]     mul_xdigit;
  logic [1:0]     mul_z = 2'b00;
  logic           mul_z_ready = 1'b0;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [2*N-1:0] z_vec;
  logic           res_err;
  logic           busy;

  msdf_mul_seq #(.N(N), .DELTA(DELTA), .TMO(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .x_vec       (x_vec),
    .y_in        (y_in),
    .mul_y       (mul_y),
    .mul_load_y  (mul_load_y),
    .mul_start   (mul_start),
    .mul_xdigit  (mul_xdigit),
    .mul_z       (mul_z),
    .mul_z_ready (mul_z_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .z_vec       (z_vec),
    .res_err     (res_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // One transaction: operands, mock multiplier behaviour, expected outcome.
  typedef struct {
    logic [2*N-1:0] x;
    logic [N:0]     y;
    int             s;       // FEED cycle of the first result digit
    int             k;       // number of result digits the mock emits
    bit             noise;   // spurious mul_z_ready outside FEED/DRAIN
    int             bp;      // cycles res_ready is held low in DONE
    logic [2*N-1:0] exp_z;
    bit             exp_err;
    int             exp_f;   // FEED-relative cycle at which res_valid appears
  } vec_t;

  int    n_checks = 0;
  int    n_errors = 0;
  string cur = "";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL [%s] %s: got %0h, expected %0h", cur, name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] dig(input logic [2*N-1:0] x, input int k);
    logic [2*N-1:0] t;
    t = x >> (2 * k);
    return t[1:0];
  endfunction

  function automatic logic [2*N-1:0] keep(input logic [2*N-1:0] x, input int c);
    logic [2*N-1:0] r;
    r = '0;
    for (int k = 0; k < c && k < N; k++) r[2*k +: 2] = x[2*k +: 2];
    return r;
  endfunction

  function automatic logic [2*N-1:0] rand_digits();
    logic [2*N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 2))
        0:       r[2*k +: 2] = DZ;
        1:       r[2*k +: 2] = DP;
        default: r[2*k +: 2] = DM;
      endcase
    end
    return r;
  endfunction

  // Reference: digits land at FEED cycles s, s+1, ...; the run is over at cycle DONE_TO.
  function automatic void model(input int s, input int k, output int c, output bit err, output int f);
    int avail;
    avail = DONE_TO - s;
    if (avail < 0) avail = 0;
    c = k;
    if (c > N) c = N;
    if (c > avail) c = avail;
    if (c == N) begin
      err = 1'b0;
      f   = s + N;
    end else begin
      err = 1'b1;
      f   = DONE_TO;
    end
  endfunction

  function automatic vec_t mk(input logic [2*N-1:0] x, input logic [N:0] y, input int s, input int k,
                              input bit noise, input int bp);
    vec_t v;
    int   c;
    v.x = x; v.y = y; v.s = s; v.k = k; v.noise = noise; v.bp = bp;
    model(s, k, c, v.exp_err, v.exp_f);
    v.exp_z = keep(x, c);
    return v;
  endfunction

  // Mock multiplier output for FEED-relative cycle f.
  task automatic mock(input vec_t v, input int f);
    int i;
    i = f - v.s;
    if (i >= 0 && i < v.k) begin
      mul_z_ready = 1'b1;
      mul_z       = (i < N) ? dig(v.x, i) : DM;
    end else if (v.noise && f >= v.exp_f) begin
      mul_z_ready = 1'b1;
      mul_z       = DP;
    end else begin
      mul_z_ready = 1'b0;
      mul_z       = DZ;
    end
  endtask

  task automatic handshake(input vec_t v);
    int waitc;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      step();
      waitc++;
    end
    check("req_ready_idle", req_ready, 1);
    req_valid   = 1'b1;
    x_vec       = v.x;
    y_in        = v.y;
    mul_z_ready = v.noise;
    mul_z       = DM;
    step();
    req_valid = 1'b0;
    x_vec     = 16'($urandom);
    y_in      = 9'($urandom);
    // LOAD cycle
    check("load_pulse", {mul_load_y, mul_start}, 2'b10);
    check("mul_y_load", mul_y, v.y);
    check("busy_load", {busy, req_ready}, 2'b10);
    check("xdig_load", mul_xdigit, DZ);
    step();
    // START cycle
    check("start_pulse", {mul_load_y, mul_start}, 2'b01);
    check("xdig_start", mul_xdigit, DZ);
    check("mul_y_start", mul_y, v.y);
    step();
  endtask

  task automatic run_txn(input vec_t v);
    int f;
    bit got;
    handshake(v);
    f   = 0;
    got = 1'b0;
    while (f < 64) begin
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      check("xdigit", mul_xdigit, (f < N) ? dig(v.x, f) : DZ);
      check("pulses_idle", {mul_load_y, mul_start, busy, req_ready}, 4'b0010);
      mock(v, f);
      step();
      f++;
    end
    check("done_reached", got, 1);
    if (got) begin
      check("done_cycle", f, v.exp_f);
      check("z_vec", z_vec, v.exp_z);
      check("res_err", res_err, v.exp_err);
      check("mul_y_done", mul_y, v.y);
      res_ready = 1'b0;
      for (int b = 0; b < v.bp; b++) begin
        mock(v, f);
        step();
        f++;
        check("bp_valid", res_valid, 1);
        check("bp_z_vec", z_vec, v.exp_z);
        check("bp_err", res_err, v.exp_err);
        check("bp_req_ready", req_ready, 0);
      end
      // Result handshake with a competing request that must not be taken.
      res_ready = 1'b1;
      req_valid = 1'b1;
      mock(v, f);
      step();
      res_ready   = 1'b0;
      req_valid   = 1'b0;
      mul_z_ready = 1'b0;
      check("after_done_valid", res_valid, 0);
      check("after_done_idle", {busy, req_ready}, 2'b01);
      check("after_done_xdig", mul_xdigit, DZ);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t           tbl[9];
    vec_t           v;
    logic [2*N-1:0] x0;
    logic [N:0]     y0;

    x0 = {DP, DM, DZ, DP, DM, DZ, DP, DP};   // digits 0..7 = +1,+1,0,-1,+1,0,-1,+1
    y0 = 9'b010001110;

    //            x   y   s   k  noise bp       exp_z          err  f
    tbl[0] = '{x0, y0,  4,  8, 1'b0, 0, x0,             1'b0, 12};   // nominal
    tbl[1] = '{x0, y0,  4,  8, 1'b0, 5, x0,             1'b0, 12};   // backpressure
    tbl[2] = '{x0, y0,  4,  3, 1'b0, 0, keep(x0, 3),    1'b1, 29};   // timeout
    tbl[3] = '{x0, y0, 10,  8, 1'b0, 1, x0,             1'b0, 18};   // late digits
    tbl[4] = '{x0, y0,  4, 10, 1'b1, 2, x0,             1'b0, 12};   // extra digits + noise
    tbl[5] = '{x0, y0,  0,  8, 1'b1, 0, x0,             1'b0,  8};   // earliest digits
    tbl[6] = '{x0, y0, 21,  8, 1'b0, 0, x0,             1'b0, 29};   // Nth on last drain cycle
    tbl[7] = '{x0, y0, 22,  8, 1'b0, 0, keep(x0, 7),    1'b1, 29};   // one digit too late
    tbl[8] = '{x0, y0,  0,  0, 1'b1, 0, 16'h0000,       1'b1, 29};   // no digits at all

    // Reset state
    cur = "reset";
    step();
    step();
    check("rst_req_ready", req_ready, 0);
    check("rst_pulses", {mul_load_y, mul_start}, 2'b00);
    check("rst_xdig", mul_xdigit, DZ);
    check("rst_mul_y", mul_y, 0);
    check("rst_res", {res_valid, res_err, busy}, 3'b000);
    check("rst_z_vec", z_vec, 0);
    rst = 1'b0;
    step();
    check("post_rst_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);

    // Directed table
    for (int t = 0; t < 9; t++) begin
      cur = $sformatf("vec%0d", t);
      run_txn(tbl[t]);
    end

    // Reset in the middle of FEED at feed_cnt = 3
    cur = "mid_reset";
    v = mk(rand_digits(), 9'($urandom), 0, 8, 1'b0, 0);
    handshake(v);
    for (int f = 0; f < 3; f++) begin
      mock(v, f);
      step();
    end
    mock(v, 3);
    rst = 1'b1;
    #1;
    mul_z_ready = 1'b0;
    check("mr_req_ready", req_ready, 0);
    check("mr_pulses", {mul_load_y, mul_start}, 2'b00);
    check("mr_xdig", mul_xdigit, DZ);
    check("mr_mul_y", mul_y, 0);
    check("mr_res", {res_valid, res_err, busy}, 3'b000);
    check("mr_z_vec", z_vec, 0);
    step();
    check("mr_hold_ready", req_ready, 0);
    rst = 1'b0;
    step();
    check("mr_release", {req_ready, busy, res_valid}, 3'b100);
    cur = "after_reset";
    run_txn(mk(rand_digits(), 9'($urandom), 4, 8, 1'b0, 0));

    // Randomized transactions against the reference model
    for (int r = 0; r < 30; r++) begin
      cur = $sformatf("rand%0d", r);
      v = mk(rand_digits(), 9'($urandom), $urandom_range(0, 24), $urandom_range(0, 12),
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
      run_txn(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msdf_mul_seq.md
MSDF_MUL_SEQ -- requirements
Module: msdf_mul_seq

Interface
REQ-001 Parameter N, default 8: number of radix-2 signed digits per operand and per result.
REQ-002 Parameter DELTA, default 4: online delay of the multiplier, in digits.
REQ-003 Parameter TMO, default 16: drain-phase timeout, in cycles.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  requester offers an operand pair.
REQ-007 req_ready  output  1  sequencer can accept a request.
REQ-008 x_vec  input  2N  X digits; digit k at [2k+1:2k]; digit 0 is the MSD; Bit_rep.vh R2_* encodings.
REQ-009 y_in  input  N+1  parallel Y operand, in the multiplier's native format.
REQ-010 mul_y  output  N+1  latched Y, driven to the multiplier.
REQ-011 mul_load_y  output  1  load strobe for the multiplier's Y register.
REQ-012 mul_start  output  1  multiplier start pulse.
REQ-013 mul_xdigit  output  2  serial X digit (xj_plus_4) to the multiplier.
REQ-014 mul_z  input  2  result digit from the multiplier.
REQ-015 mul_z_ready  input  1  mul_z is valid this cycle.
REQ-016 res_valid  output  1  z_vec and res_err are valid.
REQ-017 res_ready  input  1  consumer accepts the result.
REQ-018 z_vec  output  2N  result digits; digit k at [2k+1:2k]; digit 0 is the MSD.
REQ-019 res_err  output  1  timeout occurred; z_vec is incomplete.
REQ-020 busy  output  1  high in any state other than IDLE.

Function
REQ-021 The FSM SHALL have six states: IDLE, LOAD, START, FEED, DRAIN, DONE.
REQ-022 req_ready SHALL be 1 only in IDLE.
- A handshake (req_valid && req_ready at a rising edge) latches x_vec and y_in.
- The FSM then moves IDLE->LOAD.
REQ-023 LOAD SHALL last exactly 1 cycle with mul_load_y=1, mul_y driven from the latched Y, and the z buffer and digit counter cleared; next state START.
REQ-024 START SHALL last exactly 1 cycle with mul_start=1 and mul_xdigit=R2_ZERO; next state FEED.
REQ-025 FEED SHALL last N+DELTA+1 cycles, counted by feed_cnt = 0..N+DELTA.
- mul_xdigit = latched digit feed_cnt while feed_cnt<N.
- mul_xdigit = R2_ZERO otherwise.
- Next state DRAIN.
REQ-026 DRAIN SHALL drive mul_xdigit=R2_ZERO and count cycles.
- The FSM moves to DONE when N digits have been collected, or after TMO cycles.
- On timeout, res_err is set.
REQ-027 In FEED and DRAIN, each cycle with mul_z_ready=1 and z_cnt<N SHALL write mul_z into digit z_cnt and increment z_cnt.
- Digits arriving when z_cnt=N are discarded.
REQ-028 Collecting the Nth digit SHALL move FEED or DRAIN to DONE on the next edge, without waiting for the remainder of FEED.
REQ-029 mul_z_ready SHALL be ignored in IDLE, LOAD, START and DONE.
REQ-030 DONE SHALL hold res_valid=1 with z_vec and res_err stable until res_ready=1; then the FSM goes to IDLE and res_valid=0 on the next cycle.
REQ-031 A request SHALL NOT be accepted in the same cycle as the result handshake.
- The earliest acceptance is the first IDLE cycle.
- Back-to-back requests therefore have a one-cycle IDLE gap.
REQ-032 mul_start and mul_load_y SHALL be single-cycle pulses.
- mul_y SHALL be held constant from LOAD through DONE.
REQ-033 Outside FEED and DRAIN, mul_xdigit SHALL be R2_ZERO.
REQ-034 The nominal latency from the request handshake to res_valid SHALL be 2 + (cycle of the Nth mul_z_ready relative to FEED entry) + 1.
REQ-035 The counters SHALL be sized ceil(log2(max(N+DELTA+1, TMO)+1)) bits and SHALL NOT wrap within a transaction.

Reset
REQ-036 On rst=1, asynchronously and regardless of state:
- The FSM goes to IDLE.
- req_ready=0 while rst=1, then 1 in the first cycle after release.
- mul_start=0, mul_load_y=0, mul_xdigit=R2_ZERO, mul_y=0.
- res_valid=0, res_err=0, z_vec all R2_ZERO, busy=0.
REQ-037 A reset mid-transaction SHALL abandon it; no res_valid is produced for it.

Verification
REQ-038 Nominal: x_vec digits (MSD first) = +1,+1,0,-1,+1,0,-1,+1; y_in=9'b010001110. The mock multiplier echoes each X digit DELTA=4 cycles after FEED entry (mul_z_ready=1).
- Expected: mul_load_y pulse, then mul_start pulse one cycle later.
- Expected: the 8 digits in order, then zeros.
- Expected: res_valid with z_vec = x_vec and res_err=0.
REQ-039 Backpressure: res_ready=0 for 5 cycles while res_valid=1.
- Expected: z_vec held stable and req_ready=0 throughout.
- Expected: after res_ready=1, one IDLE cycle precedes acceptance of the next request.
REQ-040 Timeout: the mock asserts mul_z_ready only 3 times.
- Expected: DONE reached N+DELTA+1+TMO cycles after FEED entry.
- Expected: res_err=1, digits 0..2 valid, digits 3..7 = R2_ZERO.
REQ-041 Late digits: the mock emits digits starting at FEED cycle 10.
- Expected: the FSM enters DRAIN, collects all 8 digits, and reaches DONE with res_err=0.
REQ-042 Extra digits: the mock emits 10 digits.
- Expected: only the first 8 are stored; no corruption of z_vec.
REQ-043 Reset mid-FEED at feed_cnt=3.
- Expected: all outputs at reset values immediately.
- Expected: a subsequent request completes normally.
